demux_1to4: RTL and testbench
=============================

Name: demux_1to4

Overview:
- Registered 1-to-4 demultiplexer. Routes one input word stream to one of four output channels, chosen by a 2-bit selector.
- Valid/ready handshake on the input and on each output.
- One holding register per output channel.
- Per-channel accepted-word counters, readable through a selector port.
- Sits downstream of a producer; feeds four independent consumers. It is the distributing counterpart of the 4-to-1 word mux.

Parameters:
- WIDTH, 4, data word width in bits (a, b, c, d, in_data).
- CNT_WIDTH, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel: 00→a, 01→b, 10→c, 11→d.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts the input word this cycle.
- a, b, c, d  output  WIDTH each  held data of channels 0..3.
- out_valid  output  4  bit i = channel i holds a word (bit0=a .. bit3=d).
- out_ready  input  4  bit i = consumer i takes the word this cycle.
- cnt_sel  input  2  selects which channel counter drives cnt_out.
- cnt_out  output  CNT_WIDTH  accepted-word count of channel cnt_sel (combinational read).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high: sampled only on the rising clk edge.
- Reset state (effective on the edge where reset=1):
  - out_valid=0000.
  - a, b, c, d = 0.
  - All counters = 0.
  - in_ready is low during reset.
  - cnt_out reads 0 in the first cycle after reset.
- Acceptance:
  - in_ready = !reset && (!out_valid[in_sel] || out_ready[in_sel]).
  - in_ready is combinational from in_sel, out_valid and out_ready; it has no dependence on in_valid.
  - A word is accepted when in_valid && in_ready.
- Per-channel state machine, 2 states, encoded by out_valid[i]:
  - EMPTY → FULL: accept with in_sel=i. The register loads in_data; out_valid[i]=1 next cycle.
  - FULL → EMPTY: out_ready[i]=1 and no accept for channel i.
  - FULL → FULL (pass-through refill): out_ready[i]=1 and accept for channel i in the same cycle. The register loads the new word; out_valid stays 1, giving zero bubble.
  - FULL with out_ready[i]=0: hold data; input for channel i stalls (in_ready=0).
- Latency and throughput:
  - 1 cycle from accept to out_valid; no combinational path from in_data to a..d.
  - Throughput is 1 word/cycle while the destination consumer keeps ready high.
- Data integrity:
  - A channel's data is stable while out_valid[i]=1 and out_ready[i]=0.
  - Non-selected channels are never modified by an accept.
- Channel independence:
  - Consumers may drain any channel at any time, independently of the input side.
  - A stalled channel blocks the input only while in_sel points to it (head-of-line blocking by design; the producer must wait).
- Empty-channel ready: out_ready[i]=1 while out_valid[i]=0 has no effect.
- Counters:
  - counter[in_sel] increments by 1 on each accept.
  - Wraps from 2^CNT_WIDTH-1 to 0; no saturation, no flag.
  - Drains do not affect counters.
- Reset mid-operation: held words are discarded and counters cleared. An in_valid asserted during reset is not accepted and not counted.
- Unknowns: in_sel is don't-care while in_valid=0. in_ready must still be driven to a known value; an X on in_sel must not propagate into state.

Test Plan:
1. Reset, then in_data=4'h5, in_sel=00, in_valid=1 for one cycle, out_ready=0000 → next cycle a=5, out_valid=0001; cnt_sel=00 gives cnt_out=1.
2. Channel b full, out_ready[1]=0; offer in_sel=01, data=4'hA for 3 cycles → in_ready=0, b unchanged, count unchanged. Then raise out_ready[1] → accept that cycle, b=A next cycle, out_valid[1] stays 1.
3. out_ready=1111; send 4'h1,2,3,4 to sel 00,01,10,11 on consecutive cycles → each word appears on its channel exactly 1 cycle later; in_ready stays 1; each counter ends at 1.
4. Channel c full and stalled; send in_sel=11, data=4'h9 → accepted, d=9; c and its data unchanged.
5. 256 accepts to channel a with out_ready[0]=1 → cnt_out (cnt_sel=00) returns 0 after the 256th accept; other counters stay 0.
6. Channels a and d full, counters nonzero; assert reset for 1 cycle with in_valid=1 → out_valid=0000, all counters 0, nothing accepted during reset.

Source files
------------

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer with valid/ready on the input and each output channel,
// one holding register per channel and per-channel accepted-word counters.
module demux_1to4 #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [1:0]           in_sel,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     a,
   output logic [WIDTH-1:0]     b,
   output logic [WIDTH-1:0]     c,
   output logic [WIDTH-1:0]     d,
   output logic [3:0]           out_valid,
   input  logic [3:0]           out_ready,
   input  logic [1:0]           cnt_sel,
   output logic [CNT_WIDTH-1:0] cnt_out
);

   typedef enum logic {StEmpty = 1'b0, StFull = 1'b1} ch_state_e;

   ch_state_e            state_q [4];
   ch_state_e            state_d [4];
   logic [WIDTH-1:0]     data_q  [4];
   logic [CNT_WIDTH-1:0] cnt_q   [4];

   logic       sel_free;
   logic       accept;
   logic [3:0] load;

   // Decoded with a known default so an unknown in_sel still yields a defined in_ready.
   always_comb begin
      sel_free = 1'b0;
      case (in_sel)
         2'd0:    sel_free = !out_valid[0] || out_ready[0];
         2'd1:    sel_free = !out_valid[1] || out_ready[1];
         2'd2:    sel_free = !out_valid[2] || out_ready[2];
         2'd3:    sel_free = !out_valid[3] || out_ready[3];
         default: sel_free = 1'b0;
      endcase
   end

   assign in_ready = !reset && sel_free;
   assign accept   = in_valid && in_ready;

   always_comb begin
      load = '0;
      for (int i = 0; i < 4; i++) begin
         load[i] = accept && (in_sel == 2'(i));
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         unique case (state_q[i])
            StEmpty: if (load[i]) state_d[i] = StFull;
            // A load in the same cycle as a drain keeps the channel full (zero-bubble refill).
            StFull:  if (!load[i] && out_ready[i]) state_d[i] = StEmpty;
            default: state_d[i] = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= StEmpty;
            data_q[i]  <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_q[i] <= state_d[i];
            if (load[i]) begin
               data_q[i] <= in_data;
               cnt_q[i]  <= cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      out_valid = '0;
      for (int i = 0; i < 4; i++) begin
         out_valid[i] = (state_q[i] == StFull);
      end
   end

   assign a       = data_q[0];
   assign b       = data_q[1];
   assign c       = data_q[2];
   assign d       = data_q[3];
   assign cnt_out = cnt_q[cnt_sel];

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: directed scenarios followed by random traffic,
// all compared against a per-channel occupancy/count model.
module tb_demux_1to4;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in_data;
   logic [1:0]    in_sel;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a, b, c, d;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [1:0]    cnt_sel;
   logic [CW-1:0] cnt_out;

   logic [W-1:0]  dut_ch [4];

   logic [W-1:0]  m_data [4];
   bit            m_full [4];
   int unsigned   m_cnt  [4];

   int unsigned   total  = 0;
   int unsigned   passed = 0;

   demux_1to4 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt_sel   (cnt_sel),
      .cnt_out   (cnt_out)
   );

   assign dut_ch[0] = a;
   assign dut_ch[1] = b;
   assign dut_ch[2] = c;
   assign dut_ch[3] = d;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit m_ready();
      return !reset && (!m_full[in_sel] || out_ready[in_sel]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_full[i] = 1'b0;
         m_data[i] = '0;
         m_cnt[i]  = 0;
      end
   endtask

   // Applies the inputs present at the edge to the model.
   task automatic model_update();
      bit acc;
      if (reset) begin
         model_clear();
      end else begin
         acc = in_valid && m_ready();
         for (int i = 0; i < 4; i++) begin
            if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
         end
         if (acc) begin
            m_full[in_sel] = 1'b1;
            m_data[in_sel] = in_data;
            m_cnt[in_sel]  = (m_cnt[in_sel] + 1) % (1 << CW);
         end
      end
   endtask

   task automatic check_all();
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(m_full[i]));
         chk($sformatf("data[%0d]", i), 32'(dut_ch[i]), 32'(m_data[i]));
      end
      chk($sformatf("cnt_out[%0d]", cnt_sel), 32'(cnt_out), m_cnt[cnt_sel]);
   endtask

   // Entered at posedge+1; checks before the edge, then advances the model across it.
   task automatic tick();
      #3;
      check_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      reset    = 1'b0;
   endtask

   task automatic chk_counts(input string tag, input int unsigned e0, input int unsigned e1,
                             input int unsigned e2, input int unsigned e3);
      int unsigned exp [4];
      exp = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         cnt_sel = 2'(i);
         #1;
         chk($sformatf("%s_cnt%0d", tag, i), 32'(cnt_out), exp[i]);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_data   = '0;
      in_sel    = 2'd0;
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      cnt_sel   = 2'd0;
      @(posedge clk);
      #1;
      model_clear();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_cnt_out", 32'(cnt_out), 32'h0);
      reset = 1'b0;

      // 1: single accept to channel a
      in_data = 4'h5; in_sel = 2'd0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("t1_a", 32'(a), 32'h5);
      chk("t1_out_valid", 32'(out_valid), 32'h1);
      chk("t1_cnt_a", 32'(cnt_out), 32'h1);

      // 2: stall on full channel b, then pass-through refill
      in_data = 4'h3; in_sel = 2'd1; in_valid = 1'b1;
      tick();
      in_data = 4'hA;
      for (int k = 0; k < 3; k++) tick();
      chk("t2_b_held", 32'(b), 32'h3);
      cnt_sel = 2'd1;
      #1;
      chk("t2_cnt_b_held", 32'(cnt_out), 32'h1);
      out_ready = 4'b0010;
      tick();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
      chk("t2_b_new", 32'(b), 32'hA);
      chk("t2_b_valid", 32'(out_valid[1]), 32'h1);

      // 3: back-to-back to all channels with all consumers ready
      do_reset();
      out_ready = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         in_sel = 2'(k); in_data = 4'(k + 1); in_valid = 1'b1;
         tick();
         chk($sformatf("t3_ch%0d", k), 32'(dut_ch[k]), 32'(k + 1));
      end
      in_valid = 1'b0;
      chk_counts("t3", 1, 1, 1, 1);

      // 4: stalled c does not block traffic to d
      do_reset();
      out_ready = 4'b0000;
      in_sel = 2'd2; in_data = 4'h7; in_valid = 1'b1;
      tick();
      in_sel = 2'd3; in_data = 4'h9;
      tick();
      in_valid = 1'b0;
      chk("t4_d", 32'(d), 32'h9);
      chk("t4_c", 32'(c), 32'h7);
      chk("t4_out_valid", 32'(out_valid), 32'hC);

      // 5: counter wrap on channel a
      do_reset();
      out_ready = 4'b0001;
      in_sel = 2'd0; in_valid = 1'b1;
      for (int k = 0; k < 256; k++) begin
         in_data = 4'($urandom);
         tick();
      end
      in_valid = 1'b0;
      chk_counts("t5", 0, 0, 0, 0);

      // 6: reset mid-operation with in_valid high
      do_reset();
      out_ready = 4'b0000;
      in_sel = 2'd0; in_data = 4'h2; in_valid = 1'b1;
      tick();
      in_sel = 2'd3; in_data = 4'h6;
      tick();
      reset = 1'b1; in_sel = 2'd1; in_data = 4'hF;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      chk("t6_out_valid", 32'(out_valid), 32'h0);
      chk_counts("t6", 0, 0, 0, 0);

      // Random traffic
      do_reset();
      for (int k = 0; k < 600; k++) begin
         reset     = ($urandom_range(63) == 0);
         in_valid  = 1'($urandom);
         in_sel    = 2'($urandom);
         in_data   = 4'($urandom);
         out_ready = 4'($urandom);
         cnt_sel   = 2'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
